cpu_regfile_ctx: RTL

- Parametrised CPU register file. It is the successor to the fixed 6502 A/X/Y/SP/P register block.
- Provides NUM_REGS general registers with two read ports, a bus-load port and an ALU write port.
- Includes a wrapping stack pointer and a bit-masked status register.
- Adds a hardware context save/restore engine that pushes and pulls registers through the stack over a req/ack bus handshake. This is used for interrupt entry and exit without microcode sequencing.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/cpu_ctx_seq.sv | 122 ++++++++++++
 rtl/cpu_regfile_ctx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU register file and its context save/restore engine.
package cpu_pkg;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_INC  = 2'd1,
        SP_DEC  = 2'd2,
        SP_LOAD = 2'd3
    } sp_op_e;

    typedef enum logic [1:0] {
        CTX_IDLE    = 2'd0,
        CTX_SAVE    = 2'd1,
        CTX_RESTORE = 2'd2
    } ctx_state_e;

endpackage

// File: rtl/cpu_ctx_seq.sv
// Context save/restore sequencer: walks the masked registers plus status
// through the stack using a req/ack handshake.
module cpu_ctx_seq
    import cpu_pkg::*;
#(
    parameter int                  NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] CTX_MASK = NUM_REGS'(4'b0111),
    localparam int                 EW       = $clog2(NUM_REGS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          ctx_save,
    input  logic          ctx_restore,
    input  logic          ctx_ack,
    output logic          busy,
    output logic          done,
    output logic          req,
    output logic          we,
    output logic [EW-1:0] elem,
    output logic          is_status,
    output logic          push,
    output logic          pull,
    output logic          sp_inc,
    output logic          sp_dec
);

    // Element index NUM_REGS stands for the status register.
    localparam logic [EW-1:0] STATUS_IDX = EW'(NUM_REGS);

    ctx_state_e    state, state_n;
    logic [EW-1:0] idx_n;
    logic          done_n;
    logic          xfer;

    // Smallest masked register above cur (or from 0 when first), else status.
    function automatic logic [EW-1:0] save_next(input logic [EW-1:0] cur, input logic first);
        logic [EW-1:0] r;
        r = STATUS_IDX;
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (CTX_MASK[i] && (first || i > int'(cur))) r = EW'(i);
        return r;
    endfunction

    function automatic logic restore_has(input logic [EW-1:0] cur);
        logic f;
        f = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (CTX_MASK[i] && i < int'(cur)) f = 1'b1;
        return f;
    endfunction

    // Largest masked register below cur.
    function automatic logic [EW-1:0] restore_next(input logic [EW-1:0] cur);
        logic [EW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (CTX_MASK[i] && i < int'(cur)) r = EW'(i);
        return r;
    endfunction

    assign busy      = (state != CTX_IDLE);
    assign req       = busy && !stall;
    assign we        = (state == CTX_SAVE);
    assign xfer      = req && ctx_ack;
    assign push      = xfer && we;
    assign pull      = xfer && !we;
    assign sp_dec    = push;
    assign sp_inc    = pull;
    assign is_status = (elem == STATUS_IDX);

    always_comb begin
        state_n = state;
        idx_n   = elem;
        done_n  = 1'b0;
        case (state)
            CTX_IDLE: begin
                if (ctx_save) begin
                    state_n = CTX_SAVE;
                    idx_n   = save_next(elem, 1'b1);
                end else if (ctx_restore) begin
                    state_n = CTX_RESTORE;
                    idx_n   = STATUS_IDX;
                end
            end
            CTX_SAVE: begin
                if (xfer) begin
                    if (elem == STATUS_IDX) begin
                        state_n = CTX_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = save_next(elem, 1'b0);
                    end
                end
            end
            CTX_RESTORE: begin
                if (xfer) begin
                    if (restore_has(elem)) begin
                        idx_n = restore_next(elem);
                    end else begin
                        state_n = CTX_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = CTX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CTX_IDLE;
            elem  <= '0;
            done  <= 1'b0;
        end else if (!stall) begin
            state <= state_n;
            elem  <= idx_n;
            done  <= done_n;
        end
    end

endmodule

// File: rtl/cpu_regfile_ctx.sv
// Parametrised CPU register file with wrapping SP, masked status register
// and a hardware context save/restore engine on the stack.
module cpu_regfile_ctx
    import cpu_pkg::*;
#(
    parameter int                  WIDTH               = 8,
    parameter int                  NUM_REGS            = 4,
    parameter int                  SP_WIDTH            = 8,
    parameter logic [SP_WIDTH-1:0] SP_RESET            = SP_WIDTH'('hFF),
    parameter logic [WIDTH-1:0]    STATUS_RESET        = WIDTH'(8'h20),
    parameter logic [NUM_REGS-1:0] CTX_MASK            = NUM_REGS'(4'b0111),
    parameter logic [WIDTH-1:0]    STATUS_RESTORE_MASK = WIDTH'(8'hCF),
    localparam int                 RSEL                = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                wr_en,
    input  logic [RSEL-1:0]     wr_sel,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                ld_en,
    input  logic [RSEL-1:0]     ld_sel,
    input  logic [WIDTH-1:0]    ld_data,
    input  logic [RSEL-1:0]     rd_sel_a,
    input  logic [RSEL-1:0]     rd_sel_b,
    output logic [WIDTH-1:0]    rd_a,
    output logic [WIDTH-1:0]    rd_b,
    input  logic [1:0]          sp_op,
    input  logic [SP_WIDTH-1:0] sp_ld_data,
    output logic [SP_WIDTH-1:0] sp,
    output logic                sp_wrap,
    input  logic                st_en,
    input  logic [WIDTH-1:0]    st_mask,
    input  logic [WIDTH-1:0]    st_data,
    output logic [WIDTH-1:0]    status,
    input  logic                ctx_save,
    input  logic                ctx_restore,
    output logic                ctx_busy,
    output logic                ctx_done,
    output logic                ctx_req,
    output logic                ctx_we,
    output logic [SP_WIDTH-1:0] ctx_addr,
    output logic [WIDTH-1:0]    ctx_wdata,
    input  logic [WIDTH-1:0]    ctx_rdata,
    input  logic                ctx_ack
);

    localparam int EW = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [EW-1:0]                  elem;
    logic [RSEL-1:0]                elem_r;
    logic                           is_status, push, pull, sp_inc, sp_dec;
    logic [SP_WIDTH-1:0]            sp_n;
    logic                           wrap_n;

    cpu_ctx_seq #(
        .NUM_REGS (NUM_REGS),
        .CTX_MASK (CTX_MASK)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .ctx_save    (ctx_save),
        .ctx_restore (ctx_restore),
        .ctx_ack     (ctx_ack),
        .busy        (ctx_busy),
        .done        (ctx_done),
        .req         (ctx_req),
        .we          (ctx_we),
        .elem        (elem),
        .is_status   (is_status),
        .push        (push),
        .pull        (pull),
        .sp_inc      (sp_inc),
        .sp_dec      (sp_dec)
    );

    assign elem_r    = elem[RSEL-1:0];
    assign rd_a      = regs[rd_sel_a];
    assign rd_b      = regs[rd_sel_b];
    assign ctx_addr  = ctx_we ? sp : sp + SP_WIDTH'(1);
    assign ctx_wdata = is_status ? status : regs[elem_r];

    // While the engine owns the masked registers, only unmasked ones take writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (!stall) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (pull && !is_status && elem_r == RSEL'(i))
                    regs[i] <= ctx_rdata;
                else if (ld_en && ld_sel == RSEL'(i) && !(ctx_busy && CTX_MASK[i]))
                    regs[i] <= ld_data;
                else if (wr_en && wr_sel == RSEL'(i) && !(ctx_busy && CTX_MASK[i]))
                    regs[i] <= wr_data;
            end
        end
    end

    // Engine transfers move SP; the external sp_op is locked out while busy.
    always_comb begin
        sp_n   = sp;
        wrap_n = 1'b0;
        if (sp_dec) begin
            sp_n   = sp - SP_WIDTH'(1);
            wrap_n = (sp == '0);
        end else if (sp_inc) begin
            sp_n   = sp + SP_WIDTH'(1);
            wrap_n = &sp;
        end else if (!ctx_busy) begin
            case (sp_op_e'(sp_op))
                SP_INC: begin
                    sp_n   = sp + SP_WIDTH'(1);
                    wrap_n = &sp;
                end
                SP_DEC: begin
                    sp_n   = sp - SP_WIDTH'(1);
                    wrap_n = (sp == '0);
                end
                SP_LOAD: sp_n = sp_ld_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp      <= SP_RESET;
            sp_wrap <= 1'b0;
        end else if (!stall) begin
            sp      <= sp_n;
            sp_wrap <= wrap_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            status <= STATUS_RESET;
        else if (!stall) begin
            if (pull && is_status)
                status <= (status & ~STATUS_RESTORE_MASK) | (ctx_rdata & STATUS_RESTORE_MASK);
            else if (st_en && !ctx_busy)
                status <= (status & ~st_mask) | (st_data & st_mask);
        end
    end

endmodule
